// File: rtl/wb_stage_if.sv
// MiniMIPS32 MEM->WB bundle: MEM-stage result fields
// plus the data RAM read word that arrives a cycle later.
interface wb_stage_if;
   logic        mem_valid;
   logic [4:0]  mem_wa;
   logic        mem_wreg;
   logic [31:0] mem_dreg;
   logic        mem_mreg;
   logic [2:0]  mem_load_op;
   logic [1:0]  mem_addr_lo;
   logic        mem_whilo;
   logic [63:0] mem_hilo;
   logic [31:0] dm_rdata;

   modport master (
      output mem_valid, mem_wa, mem_wreg, mem_dreg,
      output mem_mreg, mem_load_op, mem_addr_lo,
      output mem_whilo, mem_hilo, dm_rdata
   );

   modport slave (
      input mem_valid, mem_wa, mem_wreg, mem_dreg,
      input mem_mreg, mem_load_op, mem_addr_lo,
      input mem_whilo, mem_hilo, dm_rdata
   );
endinterface

// File: rtl/wb_stage.sv
// MiniMIPS32 MEM->WB pipeline register and writeback datapath:
// load extraction, stall/flush handling, GPR and HI/LO write ports.
module wb_stage (
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst_n,
   input  logic        stall,
   input  logic        flush,
   wb_stage_if.slave   mem,
   output logic [4:0]  wb_wa,
   output logic [31:0] wb_wd,
   output logic        wb_we,
   output logic        wb_whilo,
   output logic [63:0] wb_hilo,
   output logic        wb_misalign
);
   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LB  = 3'd1;
   localparam logic [2:0] OP_LBU = 3'd2;
   localparam logic [2:0] OP_LH  = 3'd3;
   localparam logic [2:0] OP_LHU = 3'd4;

   logic        valid_q, wreg_q, mreg_q, whilo_q;
   logic [4:0]  wa_q;
   logic [31:0] dreg_q;
   logic [2:0]  op_q;
   logic [1:0]  off_q;
   logic [63:0] hilo_q;
   logic        held_q;
   logic [31:0] rdata_hold_q;

   always_ff @(posedge cpu_clk_50M) begin
      if (!cpu_rst_n) begin
         valid_q      <= 1'b0;
         wreg_q       <= 1'b0;
         mreg_q       <= 1'b0;
         whilo_q      <= 1'b0;
         wa_q         <= '0;
         dreg_q       <= '0;
         op_q         <= '0;
         off_q        <= '0;
         hilo_q       <= '0;
         held_q       <= 1'b0;
         rdata_hold_q <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
         wreg_q  <= 1'b0;
         mreg_q  <= 1'b0;
         whilo_q <= 1'b0;
         held_q  <= 1'b0;
      end else if (stall) begin
         // RAM word is only valid one cycle; keep it for the release cycle
         if (!held_q && valid_q && mreg_q) begin
            rdata_hold_q <= mem.dm_rdata;
            held_q       <= 1'b1;
         end
      end else begin
         valid_q <= mem.mem_valid;
         wreg_q  <= mem.mem_wreg;
         mreg_q  <= mem.mem_mreg;
         whilo_q <= mem.mem_whilo;
         wa_q    <= mem.mem_wa;
         dreg_q  <= mem.mem_dreg;
         op_q    <= mem.mem_load_op;
         off_q   <= mem.mem_addr_lo;
         hilo_q  <= mem.mem_hilo;
         held_q  <= 1'b0;
      end
   end

   logic [31:0] word_eff;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ld_data;
   logic        rsv_op;
   logic        misalign;

   assign word_eff = held_q ? rdata_hold_q : mem.dm_rdata;
   assign byte_sel = word_eff[{off_q, 3'b000} +: 8];
   assign half_sel = (off_q == 2'd0) ? word_eff[15:0] : word_eff[31:16];

   always_comb begin
      ld_data = '0;
      rsv_op  = 1'b0;
      case (op_q)
         OP_LW:   ld_data = word_eff;
         OP_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  ld_data = {24'd0, byte_sel};
         OP_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  ld_data = {16'd0, half_sel};
         default: rsv_op  = 1'b1;
      endcase
   end

   assign misalign = valid_q & mreg_q &
      (((op_q == OP_LW) & (off_q != 2'd0)) |
       (((op_q == OP_LH) | (op_q == OP_LHU)) & off_q[0]) |
       rsv_op);

   assign wb_misalign = misalign;
   assign wb_wa       = wa_q;
   assign wb_wd       = mreg_q ? ld_data : dreg_q;
   assign wb_we       = valid_q & wreg_q & (wa_q != 5'd0) & ~misalign & ~stall;
   assign wb_whilo    = valid_q & whilo_q & ~stall;
   assign wb_hilo     = hilo_q;
endmodule

// File: tb/tb_wb_stage.sv
// Randomised self-checking bench for wb_stage against a
// behavioural model of the writeback rules.
module tb_wb_stage;
   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic [4:0]  wb_wa;
   logic [31:0] wb_wd;
   logic        wb_we;
   logic        wb_whilo;
   logic [63:0] wb_hilo;
   logic        wb_misalign;

   wb_stage_if bus ();

   wb_stage dut (
      .cpu_clk_50M (clk),
      .cpu_rst_n   (rst_n),
      .stall       (stall),
      .flush       (flush),
      .mem         (bus.slave),
      .wb_wa       (wb_wa),
      .wb_wd       (wb_wd),
      .wb_we       (wb_we),
      .wb_whilo    (wb_whilo),
      .wb_hilo     (wb_hilo),
      .wb_misalign (wb_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // model of the instruction sitting in WB
   logic        m_valid, m_wreg, m_mreg, m_whilo;
   logic [4:0]  m_wa;
   logic [31:0] m_dreg;
   logic [2:0]  m_op;
   logic [1:0]  m_off;
   logic [63:0] m_hilo;
   logic        m_have_word;
   logic [31:0] m_word;
   logic        m_dc;

   function automatic logic [31:0] m_extract(logic [31:0] w,
                                             logic [2:0] op,
                                             logic [1:0] off);
      logic [31:0] b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (off == 2'd0) ? (w & 32'hFFFF) : (w >> 16);
      case (op)
         3'd0:    return w;
         3'd1:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
         3'd2:    return b;
         3'd3:    return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
         3'd4:    return h;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic m_mis();
      logic bad;
      bad = (m_op > 3'd4) ||
            (m_op == 3'd0 && m_off != 2'd0) ||
            ((m_op == 3'd3 || m_op == 3'd4) && (m_off % 2 == 1));
      return m_valid && m_mreg && bad;
   endfunction

   function automatic logic [103:0] exp_vec();
      logic [31:0] w, wd;
      logic we, wh, mis;
      w   = m_have_word ? m_word : bus.dm_rdata;
      mis = m_mis();
      wd  = m_mreg ? m_extract(w, m_op, m_off) : m_dreg;
      we  = m_valid && m_wreg && m_wa != 5'd0 && !mis && !stall;
      wh  = m_valid && m_whilo && !stall;
      return {m_wa, wd, we, wh, m_hilo, mis};
   endfunction

   function automatic logic [103:0] exp_mask();
      if (m_dc) return {5'd0, 32'd0, 2'b11, 64'd0, 1'b1};
      return {104{1'b1}};
   endfunction

   function automatic logic [103:0] obs_vec();
      return {wb_wa, wb_wd, wb_we, wb_whilo, wb_hilo, wb_misalign};
   endfunction

   task automatic model_edge();
      if (!rst_n) begin
         {m_valid, m_wreg, m_mreg, m_whilo} = '0;
         m_wa = '0; m_dreg = '0; m_op = '0; m_off = '0;
         m_hilo = '0; m_have_word = 1'b0; m_word = '0; m_dc = 1'b0;
      end else if (flush) begin
         {m_valid, m_wreg, m_mreg, m_whilo} = '0;
         m_have_word = 1'b0;
         m_dc = 1'b1;
      end else if (stall) begin
         if (!m_have_word && m_valid && m_mreg) begin
            m_have_word = 1'b1;
            m_word = bus.dm_rdata;
         end
      end else begin
         m_valid = bus.mem_valid; m_wreg = bus.mem_wreg;
         m_mreg = bus.mem_mreg; m_whilo = bus.mem_whilo;
         m_wa = bus.mem_wa; m_dreg = bus.mem_dreg;
         m_op = bus.mem_load_op; m_off = bus.mem_addr_lo;
         m_hilo = bus.mem_hilo;
         m_have_word = 1'b0; m_dc = 1'b0;
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mem(logic v, logic [4:0] wa, logic wreg,
                          logic [31:0] dreg, logic mreg,
                          logic [2:0] op, logic [1:0] off,
                          logic whilo, logic [63:0] hilo);
      bus.mem_valid = v; bus.mem_wa = wa; bus.mem_wreg = wreg;
      bus.mem_dreg = dreg; bus.mem_mreg = mreg;
      bus.mem_load_op = op; bus.mem_addr_lo = off;
      bus.mem_whilo = whilo; bus.mem_hilo = hilo;
   endtask

   task automatic set_idle();
      set_mem(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0, 64'd0);
   endtask

   task automatic test_reset();
      logic [103:0] e;
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      bus.dm_rdata = 32'hA5A5_A5A5;
      set_mem(1'b1, 5'd3, 1'b1, 32'hFFFF_FFFF, 1'b0, 3'd0, 2'd0,
              1'b1, 64'hFFFF);
      cycle();
      cycle();
      #1;
      e = exp_vec();
      checks++;
      if (obs_vec() !== e || e !== '0)
         $display("FAIL reset got=%h exp=%h", obs_vec(), 104'd0);
      if (obs_vec() !== e || e !== '0) errors++;
      rst_n = 1'b1;
      set_idle();
      cycle();
   endtask

   task automatic test_alu();
      logic [103:0] e, k;
      set_mem(1'b1, 5'd5, 1'b1, 32'h1234_5678, 1'b0, 3'd0, 2'd0,
              1'b0, 64'd0);
      cycle();
      set_idle();
      #1;
      e = exp_vec(); k = exp_mask();
      checks++;
      if ((obs_vec() & k) !== (e & k) || wb_wa !== 5'd5 ||
          wb_wd !== 32'h1234_5678 || wb_we !== 1'b1) begin
         errors++;
         $display("FAIL alu got=%h exp=%h", obs_vec(), e);
      end
      set_mem(1'b1, 5'd6, 1'b0, 32'h0, 1'b0, 3'd0, 2'd0,
              1'b1, 64'hDEAD_0001_CAFE_0002);
      cycle();
      set_idle();
      #1;
      checks++;
      if (wb_whilo !== 1'b1 || wb_hilo !== 64'hDEAD_0001_CAFE_0002 ||
          wb_we !== 1'b0) begin
         errors++;
         $display("FAIL hilo got=%b/%h exp=1/%h", wb_whilo, wb_hilo,
                  64'hDEAD_0001_CAFE_0002);
      end
   endtask

   task automatic test_loads();
      logic [2:0]  ops  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      logic [1:0]  offs [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
      logic [31:0] want [5] = '{32'hFFFF_FF80, 32'h0000_007F,
                                32'hFFFF_80FF, 32'h0000_7F01,
                                32'h80FF_7F01};
      logic [103:0] e, k;
      for (int i = 0; i < 5; i++) begin
         set_mem(1'b1, 5'(i + 10), 1'b1, $urandom, 1'b1, ops[i], offs[i],
                 1'b0, 64'd0);
         cycle();
         set_idle();
         bus.dm_rdata = 32'h80FF_7F01;
         #1;
         e = exp_vec(); k = exp_mask();
         checks++;
         if ((obs_vec() & k) !== (e & k) || wb_wd !== want[i] ||
             wb_we !== 1'b1) begin
            errors++;
            $display("FAIL load%0d got=%h we=%b exp=%h", i, wb_wd, wb_we,
                     want[i]);
         end
      end
      for (int i = 0; i < 40; i++) begin
         set_mem(1'b1, 5'($urandom), 1'b1, $urandom, 1'b1,
                 3'($urandom_range(0, 4)), 2'($urandom), 1'b0, 64'd0);
         cycle();
         set_idle();
         bus.dm_rdata = $urandom;
         #1;
         e = exp_vec(); k = exp_mask();
         checks++;
         if ((obs_vec() & k) !== (e & k)) begin
            errors++;
            $display("FAIL rndload got=%h exp=%h", obs_vec(), e);
         end
      end
   endtask

   task automatic test_stall();
      logic [103:0] e, k;
      set_mem(1'b1, 5'd9, 1'b1, 32'h0, 1'b1, 3'd0, 2'd0, 1'b0, 64'd0);
      cycle();
      for (int c = 0; c < 3; c++) begin
         set_mem(1'b1, 5'($urandom), 1'b1, $urandom, 1'b0, 3'd0, 2'd0,
                 1'b1, {$urandom, $urandom});
         stall = 1'b1;
         bus.dm_rdata = (c == 0) ? 32'h0BAD_F00D : 32'hDEAD_BEEF;
         #1;
         e = exp_vec(); k = exp_mask();
         checks++;
         if ((obs_vec() & k) !== (e & k) || wb_we !== 1'b0) begin
            errors++;
            $display("FAIL stall%0d got=%h exp=%h", c, obs_vec(), e);
         end
         cycle();
      end
      stall = 1'b0;
      set_idle();
      #1;
      e = exp_vec(); k = exp_mask();
      checks++;
      if ((obs_vec() & k) !== (e & k) || wb_we !== 1'b1 ||
          wb_wd !== 32'h0BAD_F00D || wb_wa !== 5'd9) begin
         errors++;
         $display("FAIL stall_release got=%h we=%b exp=%h", wb_wd, wb_we,
                  32'h0BAD_F00D);
      end
      cycle();
   endtask

   task automatic test_flush();
      logic [103:0] e, k;
      set_mem(1'b1, 5'd7, 1'b1, 32'h55, 1'b0, 3'd0, 2'd0, 1'b1, 64'h1);
      stall = 1'b1; flush = 1'b1;
      cycle();
      stall = 1'b0; flush = 1'b0;
      set_mem(1'b1, 5'd0, 1'b1, 32'h77, 1'b0, 3'd0, 2'd0, 1'b0, 64'd0);
      #1;
      e = exp_vec(); k = exp_mask();
      checks++;
      if ((obs_vec() & k) !== (e & k) || wb_we !== 1'b0 ||
          wb_whilo !== 1'b0) begin
         errors++;
         $display("FAIL flush got=%b%b exp=00", wb_we, wb_whilo);
      end
      cycle();
      set_idle();
      #1;
      e = exp_vec(); k = exp_mask();
      checks++;
      if ((obs_vec() & k) !== (e & k) || wb_we !== 1'b0) begin
         errors++;
         $display("FAIL wa0 got=%b exp=0", wb_we);
      end
   endtask

   task automatic test_misalign();
      logic [2:0] ops  [3] = '{3'd0, 3'd3, 3'd3};
      logic [1:0] offs [3] = '{2'd2, 2'd1, 2'd2};
      logic       mis  [3] = '{1'b1, 1'b1, 1'b0};
      logic [103:0] e, k;
      for (int i = 0; i < 3; i++) begin
         set_mem(1'b1, 5'd12, 1'b1, 32'h0, 1'b1, ops[i], offs[i],
                 1'b0, 64'd0);
         cycle();
         set_idle();
         bus.dm_rdata = $urandom;
         #1;
         e = exp_vec(); k = exp_mask();
         checks++;
         if ((obs_vec() & k) !== (e & k) || wb_misalign !== mis[i] ||
             wb_we !== !mis[i]) begin
            errors++;
            $display("FAIL misalign%0d got=%b/%b exp=%b/%b", i,
                     wb_misalign, wb_we, mis[i], !mis[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [103:0] e, k;
      set_mem(1'b1, 5'd9, 1'b1, 32'h0, 1'b1, 3'd0, 2'd0, 1'b0, 64'd0);
      cycle();
      stall = 1'b1;
      bus.dm_rdata = 32'h1357_9BDF;
      set_idle();
      cycle();
      rst_n = 1'b0;
      cycle();
      #1;
      e = exp_vec();
      checks++;
      if (obs_vec() !== e || e !== '0) begin
         errors++;
         $display("FAIL reset_mid got=%h exp=%h", obs_vec(), 104'd0);
      end
      rst_n = 1'b1; stall = 1'b0;
      set_mem(1'b1, 5'd4, 1'b1, 32'h0, 1'b1, 3'd0, 2'd0, 1'b0, 64'd0);
      cycle();
      set_idle();
      bus.dm_rdata = 32'h1122_3344;
      #1;
      e = exp_vec(); k = exp_mask();
      checks++;
      if ((obs_vec() & k) !== (e & k) || wb_wd !== 32'h1122_3344 ||
          wb_we !== 1'b1) begin
         errors++;
         $display("FAIL post_reset got=%h we=%b exp=%h", wb_wd, wb_we,
                  32'h1122_3344);
      end
   endtask

   task automatic test_random();
      logic [103:0] e, k;
      for (int i = 0; i < 400; i++) begin
         set_mem(1'($urandom), 5'($urandom), 1'($urandom), $urandom,
                 1'($urandom), 3'($urandom), 2'($urandom), 1'($urandom),
                 {$urandom, $urandom});
         stall = ($urandom_range(0, 9) < 3);
         flush = ($urandom_range(0, 9) == 0);
         rst_n = ($urandom_range(0, 39) != 0);
         bus.dm_rdata = $urandom;
         #1;
         e = exp_vec(); k = exp_mask();
         checks++;
         if ((obs_vec() & k) !== (e & k)) begin
            errors++;
            $display("FAIL random%0d got=%h exp=%h", i, obs_vec(), e);
         end
         cycle();
      end
      rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_loads();
      test_stall();
      test_flush();
      test_misalign();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
